// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Purpose:
//   Bundles every handshake and bus signal around mem_bus_arbiter: the
//   instruction-fetch requester (i_*), the load/store requester (d_*), the
//   pipeline stall request and the single-port memory bus (mem_*). Signal
//   names keep the arbiter's point of view (_i = into the arbiter,
//   _o = out of the arbiter) so both sides read the same names.
//
// Parameters:
//   ADDR_W  address width, all ports
//   DATA_W  data width; DATA_W/8 byte selects
//
// Modports:
//   slave   the arbiter itself (takes requests and memory responses,
//           drives acks, read data, stall and the memory bus)
//   master  the surroundings (core requesters plus the memory)
//
// Signals:
//   i_req_i, i_addr_i              fetch request and address
//   i_rdata_o, i_ack_o             fetch data and one-cycle completion pulse
//   d_req_i, d_we_i, d_sel_i,
//   d_addr_i, d_wdata_i            load/store request, direction, byte
//                                  enables, address, store data
//   d_rdata_o, d_ack_o             load data and one-cycle completion pulse
//   err_o                          timeout flag, pulses with an aborted ack
//   stall_req_o                    pipeline stall while a request is pending
//   mem_ce_o, mem_we_o, mem_sel_o,
//   mem_addr_o, mem_wdata_o        memory command
//   mem_rdata_i, mem_ack_i         memory response
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // Instruction fetch requester
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_ack_o;

    // Load/store requester
    logic              d_req_i;
    logic              d_we_i;
    logic [SEL_W-1:0]  d_sel_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;

    // Status towards pipeline control
    logic              err_o;
    logic              stall_req_o;

    // Single-port memory bus
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [SEL_W-1:0]  mem_sel_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_rdata_o, i_ack_o,
        input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_ack_o,
        output err_o, stall_req_o,
        output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_rdata_o, i_ack_o,
        output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_ack_o,
        input  err_o, stall_req_o,
        input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares one single-port memory bus between the OpenMIPS instruction fetch
//   (I) and load/store (D) units. One requester is granted per transaction,
//   load/store has fixed priority, memory acknowledge latency may be any
//   number of cycles >= 1, and read data is returned on a one-cycle ack.
//   A combinational stall request holds the pipeline while a request waits.
//
//   Transaction shape: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE.
//   The DONE cycle carries the ack and never samples requests, so a
//   requester that drops its request on the ack cycle is not granted again.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (DATA_W/8 byte selects)
//   TIMEOUT  max BUSY cycles before abort; only used when the watchdog is
//            built (macro MEM_ARB_TIMEOUT_EN defined). Without the macro a
//            BUSY state waits for mem_ack_i indefinitely and err_o is 0.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-low reset
//   bus   mem_bus_arbiter_if.slave: requester handshakes, stall request and
//         the memory bus (see the interface file for the signal list)
//
// Configuration macro:
//   MEM_ARB_TIMEOUT_EN  builds the BUSY watchdog counter and err_o.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    // Owner of the current (or last) transaction; steers the DONE-cycle ack.
    logic              is_data_q,   is_data_d;
    logic              mem_we_q,    mem_we_d;
    logic [SEL_W-1:0]  mem_sel_q,   mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    // At least 8 bits, wider if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    // The counter holds the number of completed BUSY cycles without an ack,
    // so it reads TIMEOUT-1 during the TIMEOUT-th BUSY cycle.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect in this build; kept so both builds share one
    // parameter list.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    logic mem_ce;
    logic i_ack;
    logic d_ack;

    // -------------------------------------------------------------------------
    // State register (FSM state plus the bus/data registers it steers)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: rst is sampled only at the clock edge, so reset is just the
        // highest-priority term of every register's next value; <= keeps all
        // registers sampling pre-edge values regardless of statement order.
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_data_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            is_data_q   <= is_data_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        is_data_d   = is_data_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;     // err is a one-cycle flag living in DONE
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Load/store has fixed priority over fetch.
                if (bus.d_req_i) begin
                    state_d     = ST_BUSY_D;
                    is_data_d   = 1'b1;
                    mem_we_d    = bus.d_we_i;
                    mem_sel_d   = bus.d_sel_i;
                    mem_addr_d  = bus.d_addr_i;
                    mem_wdata_d = bus.d_wdata_i;
                end else if (bus.i_req_i) begin
                    state_d     = ST_BUSY_I;
                    is_data_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_sel_d   = '1;       // fetches are always full words
                    mem_addr_d  = bus.i_addr_i;
                    mem_wdata_d = '0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            ST_BUSY_I, ST_BUSY_D: begin
                // Bus fields are held by the defaults above for the whole BUSY.
                if (bus.mem_ack_i) begin
                    state_d = ST_DONE;
                    if (state_q == ST_BUSY_I) begin
                        i_rdata_d = bus.mem_rdata_i;
                    end else if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata_i;  // stores keep d_rdata
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // An ack on the timeout edge takes the branch above instead.
                else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (state_q == ST_BUSY_I) begin
                        i_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
                // Requests are deliberately not sampled here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (decoded from the registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        mem_ce = 1'b0;
        i_ack  = 1'b0;
        d_ack  = 1'b0;
        unique case (state_q)
            ST_BUSY_I, ST_BUSY_D: mem_ce = 1'b1;
            ST_DONE: begin
                i_ack = !is_data_q;
                d_ack =  is_data_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_ce_o    = mem_ce;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_sel_o   = mem_sel_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    assign bus.i_ack_o     = i_ack;
    assign bus.i_rdata_o   = i_rdata_q;
    assign bus.d_ack_o     = d_ack;
    assign bus.d_rdata_o   = d_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err_o       = err_q;
`else
    assign bus.err_o       = 1'b0;
`endif

    // Combinational so the pipeline stalls in the same cycle a request
    // appears, and releases in the ack cycle.
    assign bus.stall_req_o = (bus.i_req_i & ~i_ack) | (bus.d_req_i & ~d_ack);

endmodule
